// File: rtl/inst_wait_stage.sv
// Instruction-response stage: pairs the fetch slot's PC/exception with its in-order bus response.
// Latency: valid_o rises one edge after the entry completes (response or exception present).
// Backpressure: stalled decode holds the response in rdata_q and keeps ready_o low, throttling fetch.
module inst_wait_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        cancelled_i,
    input  logic        exc_i,
    input  logic        exc_miss_i,
    input  logic [4:0]  exccode_i,
    output logic        ready_o,
    input  logic        cancel_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    input  logic        ready_i
);

    logic        got_q;
    logic [31:0] rdata_q;
    logic        drop_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        exc_q;
    logic        exc_miss_q;
    logic [4:0]  exccode_q;

    logic        rsp;
    logic [31:0] data;
    logic        complete;
    logic        kill;
    logic        out_free;
    logic        leave;
    logic        load;

    assign rsp      = inst_data_ok | got_q;
    assign data     = got_q ? rdata_q : inst_rdata;
    assign complete = valid_i & (exc_i | rsp);
    assign kill     = cancelled_i | drop_q | cancel_i;
    assign out_free = ~valid_q | ready_i | cancel_i;
    // A killed entry never needs the output slot, so it may leave even under backpressure.
    assign ready_o  = ~reset & (~valid_i | (complete & (kill | out_free)));
    assign leave    = valid_i & ready_o;
    assign load     = leave & ~kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            got_q      <= 1'b0;
            rdata_q    <= 32'h0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            inst_q     <= 32'h0;
            exc_q      <= 1'b0;
            exc_miss_q <= 1'b0;
            exccode_q  <= 5'h0;
        end else begin
            if (leave) begin
                got_q  <= 1'b0;
                drop_q <= 1'b0;
            end else if (valid_i) begin
                if (inst_data_ok) begin
                    got_q   <= 1'b1;
                    rdata_q <= inst_rdata;
                end
                if (cancel_i) begin
                    drop_q <= 1'b1;
                end
            end

            if (cancel_i) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q    <= 1'b1;
                pc_q       <= pc_i;
                inst_q     <= exc_i ? 32'h0 : data;
                exc_q      <= exc_i;
                exc_miss_q <= exc_miss_i;
                exccode_q  <= exccode_i;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign exc_o      = exc_q;
    assign exc_miss_o = exc_miss_q;
    assign exccode_o  = exccode_q;

endmodule

// File: doc/inst_wait_stage.md
# inst_wait_stage

Instruction-response stage sitting directly downstream of the fetch stage: it takes the fetch output slot (a PC whose bus request was accepted, or a fetch-side exception) and waits for the matching in-order `inst_data_ok`/`inst_rdata` response. It pairs the response with its PC and exception fields, discards responses for cancelled entries, and presents complete instructions to decode through a registered valid/ready handshake. Its `ready_o` is the fetch stage's `ready_i`, so it also throttles fetch to one outstanding request.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_data_ok`  in  1  bus response strobe; one per accepted fetch request, in order.
- `inst_rdata`  in  32  instruction word, valid while `inst_data_ok`=1.
- `valid_i`  in  1  fetch slot holds an entry.
- `pc_i`  in  32  entry PC.
- `cancelled_i`  in  1  entry was cancelled while in fetch.
- `exc_i`, `exc_miss_i`  in  1 each  fetch exception / TLB refill-miss flag; `exc_i`=1 means no bus response will come.
- `exccode_i`  in  5  exception code.
- `ready_o`  out  1  entry leaves fetch slot at this edge (drives fetch `ready_i`).
- `cancel_i`  in  1  pipeline flush from exception/eret commit.
- `valid_o`, `pc_o` (32), `inst_o` (32), `exc_o`, `exc_miss_o`, `exccode_o` (5)  out  registered decode-side entry.
- `ready_i`  in  1  decode accepts `valid_o` entry at this edge.

## Operation
- Internal state: `got_q` (response already captured), `rdata_q[31:0]`, `drop_q` (entry must be discarded), plus output registers.
- `rsp` = `inst_data_ok` | `got_q`; `data` = `got_q` ? `rdata_q` : `inst_rdata`.
- `complete` = `valid_i` & (`exc_i` | `rsp`).
- `kill` = `cancelled_i` | `drop_q` | `cancel_i`.
- `out_free` = !`valid_o` | `ready_i` | `cancel_i`.
- `ready_o` = !`reset` & (!`valid_i` | (`complete` & (`kill` | `out_free`))).
- Capture: if `valid_i` & `inst_data_ok` & !`ready_o` → `got_q`<=1, `rdata_q`<=`inst_rdata`.
- `drop_q`<=1 when `valid_i` & `cancel_i` & !`ready_o`; holds until the entry leaves.
- On `ready_o` & `valid_i`: `got_q`<=0, `drop_q`<=0. If !`kill`, load the output registers from the entry. `inst_o`=`data`, or 0 when `exc_i`.
- Output regs: if `cancel_i` → `valid_o`<=0, other fields unchanged. Else if entry loaded → `valid_o`<=1. Else if `ready_i` → `valid_o`<=0.
- A cancelled entry that is not an exception still waits for its response; that response is consumed and discarded so the next response pairs correctly.
- `inst_data_ok` while `valid_i`=0 is a protocol violation: ignored, no state change.
- Reset: `valid_o`, `exc_o`, `exc_miss_o`, `got_q`, `drop_q` = 0; `pc_o`, `inst_o`, `rdata_q` = 0; `exccode_o` = 0; `ready_o` = 0 while `reset`=1.

## Timing
- Latency: response in the same cycle as `valid_i` with decode free → `valid_o`=1 at the next edge (1 cycle). A response arriving k cycles later → `valid_o` one edge after the response.
- Exception entry: `valid_o`=1 one edge after `valid_i`; no response is awaited.
- Backpressure: decode stalled with `valid_o`=1 → response is held in `rdata_q` and `ready_o`=0. Fetch therefore issues no new request, and at most one request is outstanding.
- Simultaneous `ready_i` and a new load: the output is replaced in the same edge, giving full throughput of 1 instruction/cycle when responses return every cycle.
- `cancel_i` has priority over load and hold. The output is invalid at the next edge. The in-flight entry is dropped on completion, not earlier.
- Reset mid-wait: all state is cleared. A stale response after reset falls under the `valid_i`=0 rule.

## Test plan
- Basic: `valid_i`=1, pc 0xBFC00000, `inst_data_ok`=1 same cycle with rdata 0x24080001, `ready_i`=1 → next edge `valid_o`=1, pc_o 0xBFC00000, inst_o 0x24080001; `ready_o`=1 that cycle.
- Backpressure: `ready_i`=0 with `valid_o` held; new entry pc 0xBFC00004 gets its response 0x00000000 → `ready_o`=0 and `rdata_q` captured. Raise `ready_i` → next edge pc_o 0xBFC00004, inst_o 0x00000000.
- Cancel while waiting: entry pc 0x80001000 and `cancel_i` pulse, response arrives 3 cycles later → `valid_o` stays 0 and `ready_o`=1 in the response cycle. The next entry 0xBFC00380 pairs with the next response.
- Exception entry: `valid_i`=1, `exc_i`=1, `exc_miss_i`=1, exccode 0x02, pc 0x00400003 → `valid_o`=1, `exc_o`=1, `exc_miss_o`=1, `exccode_o`=0x02, `inst_o`=0 next edge, with no `inst_data_ok` needed.
- `cancelled_i`=1 entry: the response is consumed, nothing is forwarded, and `valid_o` remains 0.
- Reset mid-wait: assert `reset` with `got_q`=1 → next edge all outputs 0 and `ready_o`=0 during reset. A following stray `inst_data_ok` with `valid_i`=0 has no effect.
